fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the LEGv8 processor. It holds the program counter in an enabled, synchronously reset register, drives the instruction-memory address, and latches the fetched word with its PC into an IF/ID pipeline register. It honours stall (hold) and flush (redirect plus bubble) requests from the hazard and branch logic. It sits directly upstream of decode.

## Interface
Parameters:
- N, 64, PC and branch-target width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- flush  input  1  redirect PC to br_target and squash the fetched word.
- br_target  input  N  redirect address; bits [1:0] ignored (forced 0).
- imem_addr  output  N  instruction-memory address; equals current PC.
- imem_rdata  input  32  instruction word, combinational read of imem_addr.
- if_pc  output  N  PC of the instruction held in IF/ID.
- if_instr  output  32  instruction held in IF/ID.
- if_valid  output  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State: pc (N), IF/ID register {if_pc, if_instr, if_valid}.
- Priority at each posedge: reset > flush > stall > normal.
- reset: pc <= RESET_PC; if_pc <= 0; if_instr <= 0; if_valid <= 0.
- flush (flush=1, regardless of stall): pc <= {br_target[N-1:2], 2'b00}; if_valid <= 0; if_pc and if_instr are don't-care but are cleared to 0.
- stall (flush=0): pc, if_pc, if_instr and if_valid all hold.
- normal: if_pc <= pc; if_instr <= imem_rdata; if_valid <= 1; pc <= pc + 4.
- Arithmetic: pc + 4 is modulo 2^N. pc = 2^N-4 wraps to 0 with no flag.
- pc[1:0] is always 0. RESET_PC[1:0] is forced to 0 inside the block.
- Reset mid-stall or mid-flush: reset wins and all state is reinitialised in that cycle.

## Timing
- imem_addr = pc, combinationally. No register between them.
- Fetch latency is 1 cycle: the word addressed in cycle k appears on if_instr/if_valid after posedge k+1.
- First valid instruction: reset is deasserted before posedge 0, and after posedge 0 if_pc=RESET_PC, if_valid=1.
- Taken-branch penalty is 1 bubble: the posedge with flush=1 produces if_valid=0, and the next posedge delivers the word at br_target.
- Stall is held for as many cycles as it stays asserted, with no limit. Outputs are stable throughout.
- Back-to-back flushes: each one redirects again. The last flush's target wins and if_valid stays 0.
- All outputs are registered except imem_addr.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32) and perf_stalls (32).
  - Both reset to 0.
  - perf_fetched increments on every normal-update posedge.
  - perf_stalls increments on every posedge with stall=1 and flush=0.
  - Both saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: the counters and their ports do not exist, and the remaining behaviour is identical.

## Structure
- Shared package fetch_pkg:
  - INSTR_W = 32
  - PC_INC = 4
  - typedef ifid_t {pc, instr, valid} for the IF/ID bundle consumed by decode
- One sub-module, ifid_reg: the IF/ID register with reset, hold (enable) and squash inputs. It is instantiated once.
- The PC register stays inline.

## Test plan
- Reset then free-run: RESET_PC=0, memory returns 32'hA000_0000 | addr. After 3 posedges, if_pc = 0, 4, 8 in turn, if_instr tracks memory, if_valid=1.
- Stall: assert stall for 2 cycles at pc=8. imem_addr stays 8, if_pc stays 4, then fetch resumes with if_pc=8.
- Flush: flush=1 with br_target=64'h100 at pc=12. Next posedge gives if_valid=0 and imem_addr=0x100. The following posedge gives if_pc=0x100, if_valid=1.
- Flush with stall together, plus a misaligned target: stall=1, flush=1, br_target=64'h203. pc becomes 0x200 and if_valid=0, so flush wins.
- Wrap and reset mid-op: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC. One posedge later pc=0. Then assert reset during stall: pc returns to RESET_PC and if_valid=0.
- FETCH_PERF_EN build: run 5 normal cycles, 3 stall cycles and 1 flush. Expect perf_fetched=5 and perf_stalls=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction-fetch stage: widths, PC step and the IF/ID bundle.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;
    localparam int PC_W    = 64;

    // IF/ID bundle as seen by decode
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: reset > squash > hold > load. Squash leaves a cleared bubble.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               squash,
    input  logic [N-1:0]       d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [N-1:0]       q_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic               q_valid
);

    logic [N-1:0]       r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (reset || squash) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (!hold) begin
            r_pc    <= d_pc;
            r_instr <= d_instr;
            r_valid <= 1'b1;
        end
    end

    assign q_pc    = r_pc;
    assign q_instr = r_instr;
    assign q_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC register, instruction-memory address and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [N-1:0]       br_target,
    output logic [N-1:0]       imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [N-1:0]       if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
`endif
);

    // Word alignment is enforced on every value that can enter the PC.
    localparam logic [N-1:0] C_ALIGN_MASK = ~N'(3);
    localparam logic [N-1:0] C_RESET_PC   = RESET_PC & C_ALIGN_MASK;

    logic [N-1:0] r_pc;
    logic [N-1:0] w_target;
    logic [N-1:0] w_pc_next;

    assign w_target  = br_target & C_ALIGN_MASK;
    assign w_pc_next = r_pc + N'(PC_INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= C_RESET_PC;
        end else if (flush) begin
            r_pc <= w_target;
        end else if (!stall) begin
            r_pc <= w_pc_next;
        end
    end

    assign imem_addr = r_pc;

    ifid_reg #(
        .N (N)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .hold    (stall),
        .squash  (flush),
        .d_pc    (r_pc),
        .d_instr (imem_rdata),
        .q_pc    (if_pc),
        .q_instr (if_instr),
        .q_valid (if_valid)
    );

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else if (!flush) begin
            if (stall) begin
                r_perf_stalls  <= sat_inc(r_perf_stalls);
            end else begin
                r_perf_fetched <= sat_inc(r_perf_fetched);
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (RESET_PC=0 and RESET_PC=2^64-4) share stimulus.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [63:0] br_target;
    logic [63:0] addr0, addr1, pc0, pc1;
    logic [31:0] rd0, rd1, in0, in1;
    logic        v0, v1;
`ifdef FETCH_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hA000_0000 | a[31:0];
    endfunction

    assign rd0 = mem_word(addr0);
    assign rd1 = mem_word(addr1);

    fetch_stage #(.N(64), .RESET_PC(64'h0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .br_target(br_target),
        .imem_addr(addr0), .imem_rdata(rd0), .if_pc(pc0), .if_instr(in0), .if_valid(v0)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf0), .perf_stalls(ps0)
`endif
    );

    fetch_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .br_target(br_target),
        .imem_addr(addr1), .imem_rdata(rd1), .if_pc(pc1), .if_instr(in1), .if_valid(v1)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf1), .perf_stalls(ps1)
`endif
    );

    typedef struct {
        logic [63:0] addr [2];
        logic [63:0] ifpc [2];
        logic [31:0] ins  [2];
        logic        vld  [2];
        logic [31:0] pf;
        logic [31:0] ps;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference state: what the fetch stage should hold after each posedge.
    logic [63:0] rp   [2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
    logic [63:0] m_pc [2];
    logic [63:0] m_ifpc [2];
    logic [31:0] m_ins [2];
    logic        m_v  [2];
    logic [31:0] m_pf, m_ps;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [63:0] t);
        exp_t e;
        reset = r; stall = s; flush = f; br_target = t;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_pc[i] = rp[i]; m_ifpc[i] = 0; m_ins[i] = 0; m_v[i] = 0;
            end else if (f) begin
                m_pc[i] = {t[63:2], 2'b00}; m_ifpc[i] = 0; m_ins[i] = 0; m_v[i] = 0;
            end else if (!s) begin
                m_ifpc[i] = m_pc[i];
                m_ins[i]  = mem_word(m_pc[i]);
                m_v[i]    = 1'b1;
                m_pc[i]   = m_pc[i] + 64'd4;
            end
            e.addr[i] = m_pc[i]; e.ifpc[i] = m_ifpc[i]; e.ins[i] = m_ins[i]; e.vld[i] = m_v[i];
        end
        if (r) begin
            m_pf = 0; m_ps = 0;
        end else if (!f && s) begin
            if (m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
        end else if (!f) begin
            if (m_pf != 32'hFFFF_FFFF) m_pf = m_pf + 1;
        end
        e.pf = m_pf; e.ps = m_ps;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compares the registered outputs just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr0", addr0, e.addr[0]);
                chk("if_pc0",     pc0,   e.ifpc[0]);
                chk("if_instr0",  {32'h0, in0}, {32'h0, e.ins[0]});
                chk("if_valid0",  {63'h0, v0},  {63'h0, e.vld[0]});
                chk("imem_addr1", addr1, e.addr[1]);
                chk("if_pc1",     pc1,   e.ifpc[1]);
                chk("if_instr1",  {32'h0, in1}, {32'h0, e.ins[1]});
                chk("if_valid1",  {63'h0, v1},  {63'h0, e.vld[1]});
`ifdef FETCH_PERF_EN
                chk("perf_fetched", {32'h0, pf0}, {32'h0, e.pf});
                chk("perf_stalls",  {32'h0, ps0}, {32'h0, e.ps});
                chk("perf_fetched1", {32'h0, pf1}, {32'h0, e.pf});
                chk("perf_stalls1",  {32'h0, ps1}, {32'h0, e.ps});
`endif
            end
        end
    end

    initial begin
        logic r, s, f;
        logic [63:0] t;
        step(1, 0, 0, 64'h0);
        step(1, 0, 0, 64'h0);
        // free run, then a two-cycle stall at pc=8
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        step(0, 1, 0, 64'h0);
        step(0, 1, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        // taken branch at pc=12, then stall+flush with misaligned target
        step(0, 0, 1, 64'h100);
        step(0, 0, 0, 64'h0);
        step(0, 1, 1, 64'h203);
        step(0, 0, 0, 64'h0);
        // back-to-back flushes, last target wins
        step(0, 0, 1, 64'h400);
        step(0, 1, 1, 64'h801);
        step(0, 0, 0, 64'h0);
        // wrap of the 64-bit PC
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        // reset during stall and during flush
        step(0, 1, 0, 64'h0);
        step(1, 1, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        step(1, 0, 1, 64'h500);
        // counter scenario: 5 normal, 3 stalls, 1 flush
        for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h0);
        step(0, 0, 1, 64'h40);
        // long stall
        for (int i = 0; i < 12; i++) step(0, 1, 0, 64'h0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 12);
            t = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) t = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            step(r, s, f, t);
        end
        step(0, 0, 0, 64'h0);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
